trace_sequencer: RTL and testbench
==================================

// Module: trace_sequencer
// PURPOSE
//  Controller for the SOML trace datapath. Sequences ROWS row-reads of Y and of
//  each candidate G from the Y/G buffers into the complex-MAC trace datapath.
//  Frames one accumulation per candidate and returns one trace(YH*G) result per
//  candidate to x_metric_calculator over a valid/ready handshake.
// PARAMETERS
//  N       16  sample width, signed, Q-format shared with the datapath
//  ROWS    4   rows of Y and G per accumulation (rows 0..ROWS-1)
//  CAND_W  4   width of candidate count; at most 2**CAND_W-1 candidates per run
//  ADDR_W  8   G-buffer address width; must satisfy ADDR_W >= CAND_W+$clog2(ROWS)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset (0 = reset)
//  start       in   1       run request; sampled only in IDLE
//  num_cand    in   CAND_W  number of candidates; latched on accepted start
//  busy        out  1       high from accepted start until done
//  done        out  1       1-cycle pulse at end of run
//  y_rd_en     out  1       Y-buffer read strobe; data returns next cycle
//  y_addr      out  2       Y row index
//  g_rd_en     out  1       G-buffer read strobe; data returns next cycle
//  g_addr      out  ADDR_W  cand*ROWS + row
//  mac_en      out  1       datapath accumulate enable; y_rd_en delayed 1 cycle
//  mac_clr     out  1       first-beat marker; datapath restarts accumulation
//  trace_vld   in   1       datapath result valid, 1 cycle, after last beat
//  trace_r     in   N       datapath trace, real part
//  trace_i     in   N       datapath trace, imaginary part
//  out_valid   out  1       result held for consumer
//  out_ready   in   1       consumer accepts when out_valid & out_ready
//  out_r       out  N       registered trace, real part
//  out_i       out  N       registered trace, imaginary part
//  out_idx     out  CAND_W  candidate index of out_r/out_i
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE. All outputs 0. Counters 0.
//  - FSM states and transitions:
//    - IDLE -> FETCH on start when num_cand!=0. IDLE -> DONE when num_cand==0.
//    - FETCH: ROWS cycles. y_rd_en=g_rd_en=1, y_addr=row, g_addr={cand,row}.
//      Goes to WAIT after row==ROWS-1.
//    - WAIT: waits for trace_vld. Latches trace_r/i into out_r/i, out_idx=cand.
//      Sets out_valid, then goes to HOLD.
//    - HOLD: on out_valid&out_ready, clears out_valid in the same edge.
//      cand+1<num_cand -> FETCH with cand+1. Otherwise -> DONE.
//    - DONE: done=1 for one cycle, busy=0, then IDLE.
//  - mac_en and mac_clr are registered copies of the read strobe and (row==0),
//    delayed 1 cycle. Exactly ROWS mac_en beats per candidate; mac_clr on the
//    first beat only.
//  - Per-candidate latency is start-of-FETCH to out_valid:
//    ROWS + 1 + datapath latency + 1 cycles. Candidates do not overlap.
//  - Held outputs: out_r/out_i/out_idx are stable while out_valid=1 and
//    out_ready=0. out_valid stays high indefinitely; no timeout.
//  - trace_vld outside WAIT is ignored and does not change out_*.
//  - start while busy is ignored. num_cand changes after start are ignored.
//  - busy=1 in FETCH/WAIT/HOLD. busy=0 in IDLE/DONE.
//  - Address rules: cand counts 0..num_cand-1, row counts 0..ROWS-1. Neither
//    wraps within a run; g_addr never exceeds num_cand*ROWS-1.
//  - Reset asserted mid-run aborts immediately. The pending result is lost and
//    done is not pulsed.
// STRUCTURE
//  - Shared package soml_pkg: state enum {IDLE,FETCH,WAIT,HOLD,DONE}, and
//    constants ROWS and CAND_W.
//  - One sub-module, trace_out_reg: out_r/out_i/out_idx holding register with
//    valid/ready. The FSM and counters stay in this module.
// TESTING
//  1 num_cand=1, Y rows all (1.0,0), G rows all (0.5,0.5), datapath model
//    -> y_addr 0,1,2,3. mac_clr on beat 0 only. out_r=out_i=4*0.5*2 (two
//    columns). out_idx=0. done 1 cycle after accept.
//  2 num_cand=3, out_ready tied 1 -> g_addr 0..11 in order. out_idx 0,1,2.
//    Exactly 12 mac_en beats. Single done pulse.
//  3 num_cand=2, out_ready low 10 cycles on idx 0 -> out_* stable. No g_rd_en
//    for cand 1 until accept.
//  4 num_cand=0 -> no reads, busy stays 0, done pulses 1 cycle after start.
//  5 start re-pulsed during FETCH, trace_vld injected in HOLD -> no restart;
//    out_* unchanged.
//  6 rst=0 asserted mid-WAIT of cand 1 -> outputs 0 asynchronously. No done.
//    A new run with num_cand=1 completes normally.

Source files
------------

// File: rtl/soml_pkg.sv
// Shared types and sizing constants for the SOML trace datapath.
// The trace controller and its output register import this package.
package soml_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DONE
    } state_t;

    localparam int ROWS   = 4;
    localparam int CAND_W = 4;

endpackage

// File: rtl/trace_out_reg.sv
// Holds one trace result for the metric stage until it is taken.
// A load only happens while the register is empty.
module trace_out_reg
    import soml_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = CAND_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [N-1:0]     i_r,
    input  logic [N-1:0]     i_i,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [N-1:0]     o_r,
    output logic [N-1:0]     o_i,
    output logic [IDX_W-1:0] o_idx
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_r     <= '0;
            o_i     <= '0;
            o_idx   <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_r     <= i_r;
            o_i     <= i_i;
            o_idx   <= i_idx;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/trace_sequencer.sv
// Row-read sequencer for the complex-MAC trace datapath: one
// accumulation per candidate, one held trace result per candidate.
module trace_sequencer
    import soml_pkg::*;
#(
    parameter int N      = 16,
    parameter int ROWS   = soml_pkg::ROWS,
    parameter int CAND_W = soml_pkg::CAND_W,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CAND_W-1:0] num_cand,
    output logic              busy,
    output logic              done,
    output logic              y_rd_en,
    output logic [1:0]        y_addr,
    output logic              g_rd_en,
    output logic [ADDR_W-1:0] g_addr,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic              trace_vld,
    input  logic [N-1:0]      trace_r,
    input  logic [N-1:0]      trace_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_r,
    output logic [N-1:0]      out_i,
    output logic [CAND_W-1:0] out_idx
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t            r_state;
    logic [CAND_W-1:0] r_cand;
    logic [CAND_W-1:0] r_num;
    logic [RW-1:0]     r_row;
    logic              r_mac_en;
    logic              r_mac_clr;

    logic w_fetch;
    logic w_last_row;
    logic w_more;
    logic w_accept;
    logic w_load;

    assign w_fetch    = (r_state == FETCH);
    assign w_last_row = (r_row == RW'(ROWS - 1));
    assign w_more     = ({1'b0, r_cand} + (CAND_W + 1)'(1))
                        < {1'b0, r_num};
    assign w_accept   = out_valid & out_ready;
    assign w_load     = (r_state == WAIT) & trace_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_num   <= '0;
            r_row   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num   <= num_cand;
                        r_cand  <= '0;
                        r_row   <= '0;
                        r_state <= (num_cand != '0) ? FETCH : DONE;
                    end
                end
                FETCH: begin
                    if (w_last_row) begin
                        r_row   <= '0;
                        r_state <= WAIT;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                WAIT: begin
                    if (trace_vld) r_state <= HOLD;
                end
                HOLD: begin
                    if (w_accept) begin
                        if (w_more) begin
                            r_cand  <= r_cand + CAND_W'(1);
                            r_state <= FETCH;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read data returns one cycle later, so the MAC strobes trail by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
        end else begin
            r_mac_en  <= w_fetch;
            r_mac_clr <= w_fetch & (r_row == '0);
        end
    end

    assign busy    = (r_state == FETCH) | (r_state == WAIT)
                   | (r_state == HOLD);
    assign done    = (r_state == DONE);
    assign y_rd_en = w_fetch;
    assign g_rd_en = w_fetch;
    assign y_addr  = w_fetch ? 2'(r_row) : 2'b0;
    assign g_addr  = w_fetch ? (ADDR_W'(r_cand) * ADDR_W'(ROWS)
                               + ADDR_W'(r_row)) : '0;
    assign mac_en  = r_mac_en;
    assign mac_clr = r_mac_clr;

    trace_out_reg #(
        .N     (N),
        .IDX_W (CAND_W)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_r     (trace_r),
        .i_i     (trace_i),
        .i_idx   (r_cand),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_r     (out_r),
        .o_i     (out_i),
        .o_idx   (out_idx)
    );

endmodule

// File: tb/tb_trace_sequencer.sv
// Bench for trace_sequencer with Y/G buffer and MAC datapath models;
// expected traces are queued at start and popped on each handshake.
module tb_trace_sequencer;
    import soml_pkg::*;

    localparam int N   = 16;
    localparam int NR  = 4;
    localparam int CW  = 4;
    localparam int AW  = 8;
    localparam int LAT = 2;

    typedef struct packed {
        logic [N-1:0]  r;
        logic [N-1:0]  i;
        logic [CW-1:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_cand = '0;
    logic          busy, done, y_rd_en, g_rd_en, mac_en, mac_clr;
    logic [1:0]    y_addr;
    logic [AW-1:0] g_addr;
    logic          trace_vld;
    logic [N-1:0]  trace_r, trace_i;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_r, out_i;
    logic [CW-1:0] out_idx;

    trace_sequencer #(
        .N(N), .ROWS(NR), .CAND_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_cand(num_cand),
        .busy(busy), .done(done),
        .y_rd_en(y_rd_en), .y_addr(y_addr),
        .g_rd_en(g_rd_en), .g_addr(g_addr),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .trace_vld(trace_vld), .trace_r(trace_r), .trace_i(trace_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Buffers and Q8.8 complex datapath model, two identical columns.
    logic signed [N-1:0] ymr [NR];
    logic signed [N-1:0] ymi [NR];
    logic signed [N-1:0] gmr [256];
    logic signed [N-1:0] gmi [256];

    function automatic int p_re(input logic signed [N-1:0] yr, yi, gr, gi);
        return ((int'(yr) * int'(gr) + int'(yi) * int'(gi)) >>> 8) * 2;
    endfunction

    function automatic int p_im(input logic signed [N-1:0] yr, yi, gr, gi);
        return ((int'(yr) * int'(gi) - int'(yi) * int'(gr)) >>> 8) * 2;
    endfunction

    function automatic exp_t ref_trace(input int c);
        int sr;
        int si;
        exp_t e;
        sr = 0;
        si = 0;
        for (int r = 0; r < NR; r++) begin
            sr += p_re(ymr[r], ymi[r], gmr[c*NR+r], gmi[c*NR+r]);
            si += p_im(ymr[r], ymi[r], gmr[c*NR+r], gmi[c*NR+r]);
        end
        e.r   = N'(sr);
        e.i   = N'(si);
        e.idx = CW'(c);
        return e;
    endfunction

    logic signed [N-1:0] yq_r, yq_i, gq_r, gq_i;
    int   acc_r, acc_i, beat, vcnt;
    logic dp_vld;
    logic [N-1:0] dp_r, dp_i;
    logic inj = 1'b0;
    logic [N-1:0] inj_r = '0;
    logic [N-1:0] inj_i = '0;

    assign trace_vld = dp_vld | inj;
    assign trace_r   = inj ? inj_r : dp_r;
    assign trace_i   = inj ? inj_i : dp_i;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            yq_r <= '0; yq_i <= '0; gq_r <= '0; gq_i <= '0;
            acc_r <= 0; acc_i <= 0; beat <= 0; vcnt <= 0;
            dp_vld <= 1'b0; dp_r <= '0; dp_i <= '0;
        end else begin
            if (y_rd_en) begin
                yq_r <= ymr[y_addr];
                yq_i <= ymi[y_addr];
            end
            if (g_rd_en) begin
                gq_r <= gmr[g_addr];
                gq_i <= gmi[g_addr];
            end
            dp_vld <= 1'b0;
            if (vcnt == 1) begin
                dp_vld <= 1'b1;
                dp_r   <= N'(acc_r);
                dp_i   <= N'(acc_i);
            end
            if (vcnt != 0) vcnt <= vcnt - 1;
            if (mac_en) begin
                acc_r <= (mac_clr ? 0 : acc_r) + p_re(yq_r, yq_i, gq_r, gq_i);
                acc_i <= (mac_clr ? 0 : acc_i) + p_im(yq_r, yq_i, gq_r, gq_i);
                beat  <= mac_clr ? 1 : beat + 1;
                if ((mac_clr ? 1 : beat + 1) == NR) vcnt <= LAT;
            end
        end
    end

    // Monitor and scoreboard.
    exp_t sb[$];
    exp_t mon_e;
    int yaq[$];
    int gaq[$];
    int cyc = 0;
    int n_yrd, n_grd, n_mac, n_clr, n_done, n_busy, n_res;
    int t_done, t_acc, t_start;
    logic [N-1:0] last_r, last_i;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (y_rd_en) begin n_yrd++; yaq.push_back(int'(y_addr)); end
            if (g_rd_en) begin n_grd++; gaq.push_back(int'(g_addr)); end
            if (mac_en) n_mac++;
            if (mac_clr) n_clr++;
            if (busy) n_busy++;
            if (done) begin n_done++; t_done = cyc; end
            if (out_valid && out_ready) begin
                t_acc = cyc;
                n_res++;
                last_r = out_r;
                last_i = out_i;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_r", out_r, mon_e.r);
                    check("out_i", out_i, mon_e.i);
                    check("out_idx", out_idx, mon_e.idx);
                end
            end
        end
    end

    task automatic clear_stats();
        n_yrd = 0; n_grd = 0; n_mac = 0; n_clr = 0;
        n_done = 0; n_busy = 0; n_res = 0;
        t_done = -1; t_acc = -1;
        yaq.delete();
        gaq.delete();
    endtask

    task automatic fill(input bit unit);
        for (int r = 0; r < NR; r++) begin
            ymr[r] = unit ? N'(256) : N'(int'($urandom_range(0, 1023)) - 512);
            ymi[r] = unit ? N'(0)   : N'(int'($urandom_range(0, 1023)) - 512);
        end
        for (int a = 0; a < 256; a++) begin
            gmr[a] = unit ? N'(128) : N'(int'($urandom_range(0, 1023)) - 512);
            gmi[a] = unit ? N'(128) : N'(int'($urandom_range(0, 1023)) - 512);
        end
    endtask

    task automatic kick(input int nc);
        for (int c = 0; c < nc; c++) sb.push_back(ref_trace(c));
        @(posedge clk); #1;
        num_cand = CW'(nc);
        start    = 1'b1;
        t_start  = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
        num_cand = ~CW'(nc);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k;
        k = 0;
        while (n_done == 0 && k < lim) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_finished"}, 64'(n_done != 0), 64'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int k;
        k = 0;
        while (!out_valid && k < lim) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    logic [2*N+CW-1:0] held;
    int g0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fill(1'b1);
        clear_stats();
        #1;
        check("rst_ctrl", {busy, done, y_rd_en, g_rd_en, mac_en, mac_clr,
                           out_valid}, 64'd0);
        check("rst_data", {out_r, out_i, out_idx, g_addr, y_addr}, 64'd0);
        #20;
        @(negedge clk) rst = 1'b1;

        // 1: single candidate, unit data
        clear_stats();
        out_ready = 1'b1;
        kick(1);
        wait_done("t1", 200);
        check("t1_ylen", yaq.size(), 4);
        for (int i = 0; i < yaq.size(); i++) check("t1_yaddr", yaq[i], i);
        check("t1_mac", n_mac, 4);
        check("t1_clr", n_clr, 1);
        check("t1_r4", last_r, 16'd1024);
        check("t1_i4", last_i, 16'd1024);
        check("t1_done_lat", t_done, t_acc + 1);
        check("t1_done_n", n_done, 1);
        check("t1_sb", sb.size(), 0);

        // 2: three candidates, consumer always ready
        fill(1'b0);
        clear_stats();
        kick(3);
        wait_done("t2", 400);
        check("t2_glen", gaq.size(), 12);
        for (int i = 0; i < gaq.size(); i++) check("t2_gaddr", gaq[i], i);
        check("t2_mac", n_mac, 12);
        check("t2_clr", n_clr, 3);
        check("t2_done_n", n_done, 1);
        check("t2_res", n_res, 3);
        check("t2_sb", sb.size(), 0);

        // 3: back-pressure on first result
        fill(1'b0);
        clear_stats();
        out_ready = 1'b0;
        kick(2);
        wait_valid("t3", 100);
        held = {out_r, out_i, out_idx};
        g0 = n_grd;
        repeat (10) begin
            @(negedge clk);
            check("t3_hold", {out_r, out_i, out_idx}, held);
        end
        check("t3_no_grd", n_grd, g0);
        check("t3_g0", g0, 4);
        check("t3_vld_held", out_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("t3", 300);
        check("t3_res", n_res, 2);
        check("t3_grd", n_grd, 8);
        check("t3_sb", sb.size(), 0);

        // 4: zero candidates
        clear_stats();
        kick(0);
        wait_done("t4", 20);
        check("t4_reads", n_yrd + n_grd, 0);
        check("t4_busy", n_busy, 0);
        check("t4_done_lat", t_done, t_start + 1);
        check("t4_done_n", n_done, 1);

        // 5: start during FETCH, stray trace_vld during HOLD
        fill(1'b0);
        clear_stats();
        out_ready = 1'b0;
        kick(2);
        @(posedge clk); #1;
        start = 1'b1;
        num_cand = CW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("t5", 100);
        held = {out_r, out_i, out_idx};
        @(posedge clk); #1;
        inj = 1'b1; inj_r = 16'h7777; inj_i = 16'h1234;
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        check("t5_inj_hold", {out_r, out_i, out_idx}, held);
        check("t5_vld", out_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("t5", 300);
        check("t5_done_n", n_done, 1);
        check("t5_res", n_res, 2);
        check("t5_grd", n_grd, 8);
        check("t5_idle", busy, 0);
        check("t5_sb", sb.size(), 0);

        // 6: reset during WAIT of candidate 1
        fill(1'b0);
        clear_stats();
        out_ready = 1'b1;
        kick(2);
        g0 = 0;
        while (n_grd < 8 && g0 < 100) begin
            @(posedge clk);
            g0++;
        end
        @(posedge clk); #2;
        check("t6_in_wait", {busy, y_rd_en, out_valid}, 3'b100);
        rst = 1'b0;
        #1;
        check("t6_rst_ctrl", {busy, done, y_rd_en, g_rd_en, mac_en, mac_clr,
                              out_valid}, 64'd0);
        check("t6_rst_data", {out_r, out_i, out_idx, g_addr, y_addr}, 64'd0);
        check("t6_res_pre", n_res, 1);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        check("t6_no_done", n_done, 0);
        fill(1'b0);
        clear_stats();
        kick(1);
        wait_done("t6", 200);
        check("t6_res", n_res, 1);
        check("t6_done_n", n_done, 1);
        check("t6_sb", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
